alu_mc: RTL and testbench

- Parametrised, multi-cycle successor to the single-cycle combinational ALU in the execute stage.
- Widens the datapath to WIDTH bits and registers every result.
- Replaces the combinational multiplier with an iterative shift-add multiplier and adds an iterative restoring divider.
- Uses a valid/ready handshake on both sides so the pipeline control can stall the execute stage while a long operation runs.

---
 rtl/alu_pkg.sv | 46 ++++
 rtl/alu_mc_iter.sv | 74 +++++++
 rtl/alu_mc.sv | 158 +++++++++++++++
 tb/tb_alu_mc.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared encodings for the multi-cycle ALU: command codes, flag bit
// positions, FSM states and a flag-packing helper.
package alu_pkg;

    localparam int unsigned ALU_PASSTHROUGH     = 0;
    localparam int unsigned ALU_ADD             = 1;
    localparam int unsigned ALU_SUBTRACT        = 2;
    localparam int unsigned ALU_MULTIPLY        = 3;
    localparam int unsigned ALU_AND             = 4;
    localparam int unsigned ALU_OR              = 5;
    localparam int unsigned ALU_COMPLEMENT      = 6;
    localparam int unsigned ALU_TWOS_COMPLEMENT = 7;
    localparam int unsigned ALU_LSR             = 8;
    localparam int unsigned ALU_ASR             = 9;
    localparam int unsigned ALU_LSL             = 10;
    localparam int unsigned ALU_ASL             = 11;
    localparam int unsigned ALU_DIVIDE          = 12;

    localparam int ZERO_FLAG    = 0;
    localparam int CARRY_FLAG   = 1;
    localparam int NEG_FLAG     = 2;
    localparam int DIVZERO_FLAG = 3;

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        DIV,
        DONE
    } state_t;

    function automatic logic [3:0] make_flags(
        input logic divzero,
        input logic neg,
        input logic carry,
        input logic zero
    );
        logic [3:0] f;
        f = '0;
        f[DIVZERO_FLAG] = divzero;
        f[NEG_FLAG]     = neg;
        f[CARRY_FLAG]   = carry;
        f[ZERO_FLAG]    = zero;
        return f;
    endfunction

endpackage

// File: rtl/alu_mc_iter.sv
// Shared iterative datapath: shift-add multiply or restoring divide,
// one step per clock over WIDTH steps.
module alu_mc_iter #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               div,
    input  logic [WIDTH-1:0]   lo_init,
    input  logic [WIDTH-1:0]   opnd_init,
    output logic               done,
    output logic [2*WIDTH-1:0] res
);

    localparam int AW = 2*WIDTH + 1;
    localparam int CW = $clog2(WIDTH);

    logic [AW-1:0]    acc;
    logic [AW-1:0]    acc_next;
    logic [AW-1:0]    shl;
    logic [WIDTH:0]   hi;
    logic [WIDTH:0]   add;
    logic [WIDTH+1:0] trial;
    logic [WIDTH-1:0] opnd;
    logic [CW-1:0]    cnt;
    logic             busy;
    logic             mode;

    // acc holds {upper partial, lower word}; the extra top bit absorbs
    // the adder carry (multiply) or the shifted-out remainder bit (divide)
    always_comb begin
        shl      = acc << 1;
        hi       = acc[AW-1:WIDTH];
        add      = acc[0] ? hi + {1'b0, opnd} : hi;
        trial    = {1'b0, shl[AW-1:WIDTH]} - {2'b00, opnd};
        acc_next = acc;
        if (mode) begin
            if (!trial[WIDTH+1])
                acc_next = {trial[WIDTH:0], shl[WIDTH-1:1], 1'b1};
            else
                acc_next = shl;
        end else begin
            acc_next = {add, acc[WIDTH-1:0]} >> 1;
        end
    end

    assign done = busy && (cnt == CW'(WIDTH-1));
    assign res  = acc_next[2*WIDTH-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc  <= '0;
            opnd <= '0;
            cnt  <= '0;
            busy <= 1'b0;
            mode <= 1'b0;
        end else if (start) begin
            acc  <= {{(WIDTH+1){1'b0}}, lo_init};
            opnd <= opnd_init;
            cnt  <= '0;
            busy <= 1'b1;
            mode <= div;
        end else if (busy) begin
            acc <= acc_next;
            cnt <= cnt + CW'(1);
            if (done) begin
                busy <= 1'b0;
                cnt  <= '0;
            end
        end
    end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle execute-stage ALU with registered result and valid/ready
// handshakes on both sides.
module alu_mc
    import alu_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CMD_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [CMD_W-1:0]   cmnd,
    input  logic [WIDTH-1:0]   primary_operand,
    input  logic [WIDTH-1:0]   secondary_operand,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] result,
    output logic [3:0]         flags
);

    localparam int RW = 2*WIDTH;

    state_t          state;
    logic [31:0]     op;
    logic            accept;
    logic            is_mul;
    logic            is_div;
    logic            div_zero;
    logic            it_start;
    logic            it_done;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] inv_a;
    logic [WIDTH-1:0] neg_a;
    logic [WIDTH:0]  sum;
    logic [WIDTH:0]  diff;
    logic [RW-1:0]   sc_res;
    logic [RW-1:0]   it_res;
    logic            sc_carry;
    logic [3:0]      sc_flags;
    logic [3:0]      it_flags;

    assign a        = primary_operand;
    assign b        = secondary_operand;
    assign op       = 32'(cmnd);
    assign accept   = in_valid && in_ready;
    assign is_mul   = (op == ALU_MULTIPLY);
    assign is_div   = (op == ALU_DIVIDE);
    assign div_zero = (b == '0);
    assign it_start = accept && (is_mul || (is_div && !div_zero));
    assign inv_a    = ~a;
    assign neg_a    = inv_a + WIDTH'(1);
    assign sum      = {1'b0, a} + {1'b0, b};
    assign diff     = {1'b0, a} - {1'b0, b};

    // unknown codes fall through to result 0, which yields ZERO alone
    always_comb begin
        sc_res   = '0;
        sc_carry = 1'b0;
        case (op)
            ALU_PASSTHROUGH:     sc_res = RW'(b);
            ALU_ADD: begin
                sc_res   = RW'(sum);
                sc_carry = sum[WIDTH];
            end
            ALU_SUBTRACT: begin
                sc_res   = RW'(diff);
                sc_carry = diff[WIDTH];
            end
            ALU_AND:             sc_res = RW'(a & b);
            ALU_OR:              sc_res = RW'(a | b);
            ALU_COMPLEMENT:      sc_res = RW'(inv_a);
            ALU_TWOS_COMPLEMENT: sc_res = RW'(neg_a);
            ALU_LSR: begin
                sc_res   = RW'({1'b0, a[WIDTH-1:1]});
                sc_carry = a[0];
            end
            ALU_ASR: begin
                sc_res   = RW'({a[WIDTH-1], a[WIDTH-1:1]});
                sc_carry = a[0];
            end
            ALU_LSL, ALU_ASL: begin
                sc_res   = RW'({a[WIDTH-2:0], 1'b0});
                sc_carry = a[WIDTH-1];
            end
            default: ;
        endcase
    end

    assign sc_flags = make_flags(1'b0, sc_res[WIDTH-1], sc_carry,
                                 sc_res[WIDTH-1:0] == '0);
    assign it_flags = (state == DIV)
        ? make_flags(1'b0, it_res[WIDTH-1], 1'b0, it_res[WIDTH-1:0] == '0)
        : make_flags(1'b0, it_res[RW-1], 1'b0, it_res == '0);

    alu_mc_iter #(.WIDTH(WIDTH)) u_iter (
        .clk       (clk),
        .rst_n     (reset),
        .start     (it_start),
        .div       (is_div),
        .lo_init   (is_div ? a : b),
        .opnd_init (is_div ? b : a),
        .done      (it_done),
        .res       (it_res)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            result    <= '0;
            flags     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    in_ready <= 1'b1;
                    if (accept) begin
                        in_ready <= 1'b0;
                        if (is_mul) begin
                            state <= MUL;
                        end else if (is_div && !div_zero) begin
                            state <= DIV;
                        end else if (is_div) begin
                            result    <= {a, {WIDTH{1'b1}}};
                            flags     <= make_flags(1'b1, 1'b1, 1'b0, 1'b0);
                            out_valid <= 1'b1;
                            state     <= DONE;
                        end else begin
                            result    <= sc_res;
                            flags     <= sc_flags;
                            out_valid <= 1'b1;
                            state     <= DONE;
                        end
                    end
                end
                MUL, DIV: begin
                    if (it_done) begin
                        result    <= it_res;
                        flags     <= it_flags;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_mc.sv
// Bench for alu_mc (WIDTH=8): directed plan plus random commands
// checked against an arithmetic reference model.
module tb_alu_mc;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  cmnd;
    logic [7:0]  primary_operand;
    logic [7:0]  secondary_operand;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] result;
    logic [3:0]  flags;

    int n_asserts = 0;
    int n_fail    = 0;

    alu_mc #(.WIDTH(8), .CMD_W(4)) dut (
        .clk               (clk),
        .reset             (reset),
        .in_valid          (in_valid),
        .in_ready          (in_ready),
        .cmnd              (cmnd),
        .primary_operand   (primary_operand),
        .secondary_operand (secondary_operand),
        .out_valid         (out_valid),
        .out_ready         (out_ready),
        .result            (result),
        .flags             (flags)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_asserts++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // flags packed as {DIVZERO, NEG, CARRY, ZERO}
    task automatic model(input int c, input int a, input int b,
                         output logic [15:0] r, output logic [3:0] f,
                         output int lat);
        int res;
        int q;
        int rm;
        logic cy;
        cy  = 1'b0;
        lat = 1;
        res = 0;
        case (c)
            0:  res = b;
            1: begin res = a + b; cy = (res > 255); end
            2: begin res = (a - b) & 'h1FF; cy = (a < b); end
            4:  res = a & b;
            5:  res = a | b;
            6:  res = 255 - a;
            7:  res = (256 - a) % 256;
            8: begin res = a / 2; cy = a % 2; end
            9: begin res = a / 2 + (a >= 128 ? 128 : 0); cy = a % 2; end
            10, 11: begin res = (a * 2) % 256; cy = (a >= 128); end
            default: res = 0;
        endcase
        r = 16'(res);
        f = {1'b0, r[7], cy, r[7:0] == 8'h00};
        if (c == 3) begin
            res = a * b;
            r   = 16'(res);
            f   = {1'b0, r[15], 1'b0, r == 16'h0};
            lat = 9;
        end else if (c == 12 && b == 0) begin
            r = 16'(a * 256 + 255);
            f = 4'b1100;
        end else if (c == 12) begin
            q   = a / b;
            rm  = a % b;
            r   = 16'(rm * 256 + q);
            f   = {1'b0, r[7], 1'b0, q == 0};
            lat = 9;
        end
    endtask

    task automatic run_op(input string tag, input int c, input int a,
                          input int b, input int stall);
        logic [15:0] er;
        logic [3:0]  ef;
        int          el;
        int          lat;
        int          t;
        logic        busy_ready;
        logic [15:0] hold_r;
        logic [3:0]  hold_f;
        model(c, a, b, er, ef, el);
        out_ready = 1'b0;
        t = 0;
        while (!in_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        check({tag, " in_ready"}, 32'(in_ready), 32'd1);
        in_valid          = 1'b1;
        cmnd              = 4'(c);
        primary_operand   = 8'(a);
        secondary_operand = 8'(b);
        @(posedge clk);
        @(negedge clk);
        in_valid          = 1'b0;
        cmnd              = 4'($urandom);
        primary_operand   = 8'($urandom);
        secondary_operand = 8'($urandom);
        lat        = 1;
        busy_ready = 1'b0;
        while (!out_valid && lat < 40) begin
            busy_ready |= in_ready;
            @(negedge clk);
            lat++;
        end
        check({tag, " latency"}, 32'(lat), 32'(el));
        check({tag, " result"}, 32'(result), 32'(er));
        check({tag, " flags"}, 32'(flags), 32'(ef));
        if (el > 1) check({tag, " busy in_ready"}, 32'(busy_ready), 32'd0);
        hold_r = result;
        hold_f = flags;
        for (int i = 0; i < stall; i++) begin
            in_valid = 1'b1;
            cmnd     = 4'd1;
            @(negedge clk);
            check({tag, " stall hold"}, {11'd0, out_valid, hold_f, hold_r},
                  {11'd0, 1'b1, flags, result});
            check({tag, " stall in_ready"}, 32'(in_ready), 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, " drain"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        reset             = 1'b0;
        in_valid          = 1'b0;
        out_ready         = 1'b0;
        cmnd              = '0;
        primary_operand   = '0;
        secondary_operand = '0;
        repeat (2) @(negedge clk);
        check("reset outs", {11'd0, in_ready, out_valid, flags, result}, 32'd0);
        reset = 1'b1;
        @(negedge clk);
        check("post-reset in_ready", 32'(in_ready), 32'd1);

        run_op("add c8+64", 1, 'hC8, 'h64, 0);
        run_op("sub 05-07", 2, 'h05, 'h07, 0);
        run_op("mul ff*ff", 3, 'hFF, 'hFF, 0);
        run_op("div 64/07", 12, 'h64, 'h07, 0);
        run_op("div 55/00", 12, 'h55, 'h00, 0);
        run_op("backpressure", 1, 'h10, 'h20, 3);
        run_op("unknown", 15, 'h12, 'h34, 0);
        run_op("asr 81", 9, 'h81, 'h00, 0);
        run_op("div 07/64", 12, 'h07, 'h64, 1);

        // reset in the middle of a multiply
        @(negedge clk);
        in_valid          = 1'b1;
        cmnd              = 4'd3;
        primary_operand   = 8'hFF;
        secondary_operand = 8'hFF;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        check("mid-mul reset", {11'd0, in_ready, out_valid, flags, result},
              32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("reset release in_ready", 32'(in_ready), 32'd1);
        check("reset no stale valid", 32'(out_valid), 32'd0);
        run_op("add 01+01", 1, 'h01, 'h01, 0);

        for (int k = 0; k < 40; k++)
            run_op("random", int'($urandom_range(0, 15)),
                   int'($urandom_range(0, 255)),
                   int'($urandom_range(0, 255)),
                   int'($urandom_range(0, 2)));
        run_op("random div0", 12, int'($urandom_range(0, 255)), 0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_asserts, n_fail);
        $finish;
    end

endmodule
